// File: rtl/fu_completion_arbiter.sv
// FU -> ROB completion arbiter: per-FU FIFOs, round-robin grant, registered ROB output with CDB pulse.
// Optional COMPL_BYPASS_EN: when every FIFO is empty, an incoming completion loads the output register directly.
module fu_completion_arbiter #(
  parameter int unsigned FU_COUNT  = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [FU_COUNT-1:0]   fu_valid,
  output logic [FU_COUNT-1:0]   fu_ready,
  input  logic [FU_COUNT*4-1:0] fu_robid,
  input  logic [FU_COUNT*8-1:0] fu_flags,
  input  logic [FU_COUNT*8-1:0] fu_wbs,
  input  logic [FU_COUNT*8-1:0] fu_value,
  input  logic                  rob_ready,
  output logic                  rob_transmit,
  output logic [3:0]            rob_id,
  output logic [7:0]            rob_flags,
  output logic [7:0]            rob_wbs,
  output logic [7:0]            rob_value,
  output logic                  cdb_transmit,
  output logic [3:0]            cdb_id,
  output logic [7:0]            cdb_val
);

  localparam int unsigned IW = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] flags;
    logic [7:0] wbs;
    logic [7:0] value;
  } entry_t;

  entry_t              in_entry [FU_COUNT];
  entry_t              head     [FU_COUNT];
  entry_t              win_entry;
  logic [FU_COUNT-1:0] nonempty;
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;
  logic [IW:0]         pick;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       rr_ptr;
  logic                load_en;
  logic                grant;
  logic                bypass;
`ifdef COMPL_BYPASS_EN
  logic [IW:0]         byp_pick;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Returns {found, index}: first requester at or after base, wrapping modulo FU_COUNT.
  function automatic logic [IW:0] rr_pick(input logic [FU_COUNT-1:0] req,
                                          input logic [IW-1:0]     base);
    logic [IW:0] idx;
    logic [IW:0] res;
    res = '0;
    for (int unsigned k = 0; k < FU_COUNT; k++) begin
      idx = {1'b0, base} + (IW+1)'(k);
      if (idx >= (IW+1)'(FU_COUNT)) idx = idx - (IW+1)'(FU_COUNT);
      if (!res[IW] && req[idx[IW-1:0]]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
    entry_t        mem [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    assign in_entry[g] = {fu_robid[g*4 +: 4], fu_flags[g*8 +: 8],
                          fu_wbs[g*8 +: 8], fu_value[g*8 +: 8]};
    assign nonempty[g] = (count != '0);
    assign fu_ready[g] = !rst && (count < CW'(BUF_DEPTH));
    assign head[g]     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= next_ptr(wr_ptr);
        if (pop[g])  rd_ptr <= next_ptr(rd_ptr);
        if (push[g] && !pop[g])      count <= count + 1'b1;
        else if (pop[g] && !push[g]) count <= count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= in_entry[g];
    end
  end

  always_comb begin
    pick      = rr_pick(nonempty, rr_ptr);
    load_en   = !rob_transmit || rob_ready;
    grant     = load_en && pick[IW] && !flush;
    winner    = pick[IW-1:0];
    win_entry = head[winner];
`ifdef COMPL_BYPASS_EN
    // Only reachable when every FIFO is empty, so a bypass can never overtake buffered data.
    byp_pick = rr_pick(fu_valid & fu_ready, rr_ptr);
    bypass   = load_en && !flush && !pick[IW] && byp_pick[IW];
    if (bypass) begin
      winner    = byp_pick[IW-1:0];
      win_entry = in_entry[winner];
    end
`else
    bypass = 1'b0;
`endif
    push = fu_valid & fu_ready & {FU_COUNT{!flush}};
    pop  = '0;
    if (grant)  pop[winner]  = 1'b1;
    if (bypass) push[winner] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      rob_transmit <= 1'b0;
      rob_id       <= '0;
      rob_flags    <= '0;
      rob_wbs      <= '0;
      rob_value    <= '0;
      cdb_transmit <= 1'b0;
      cdb_id       <= '0;
      cdb_val      <= '0;
    end else if (flush) begin
      rob_transmit <= 1'b0;
      rob_id       <= '0;
      rob_flags    <= '0;
      rob_wbs      <= '0;
      rob_value    <= '0;
      cdb_transmit <= 1'b0;
      cdb_id       <= '0;
      cdb_val      <= '0;
    end else begin
      cdb_transmit <= 1'b0;
      cdb_id       <= '0;
      cdb_val      <= '0;
      if (grant || bypass) begin
        rob_transmit <= 1'b1;
        rob_id       <= win_entry.id;
        rob_flags    <= win_entry.flags;
        rob_wbs      <= win_entry.wbs;
        rob_value    <= win_entry.value;
        // The CDB pulse is tied to the load, so a stalled entry never re-broadcasts.
        if (win_entry.flags[0]) begin
          cdb_transmit <= 1'b1;
          cdb_id       <= win_entry.wbs[3:0];
          cdb_val      <= win_entry.value;
        end
        rr_ptr <= (winner == IW'(FU_COUNT - 1)) ? '0 : winner + 1'b1;
      end else if (load_en) begin
        rob_transmit <= 1'b0;
        rob_id       <= '0;
        rob_flags    <= '0;
        rob_wbs      <= '0;
        rob_value    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fu_completion_arbiter.sv
// Scoreboard bench for fu_completion_arbiter: queue-based reference model, negedge monitor, directed + random stimulus.
module tb_fu_completion_arbiter;

  localparam int N = 8;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           rob_ready;
  logic [N-1:0]   fv;
  logic [N-1:0]   fu_ready;
  logic [N*4-1:0] fu_robid;
  logic [N*8-1:0] fu_flags;
  logic [N*8-1:0] fu_wbs;
  logic [N*8-1:0] fu_value;
  logic           rob_transmit;
  logic [3:0]     rob_id;
  logic [7:0]     rob_flags;
  logic [7:0]     rob_wbs;
  logic [7:0]     rob_value;
  logic           cdb_transmit;
  logic [3:0]     cdb_id;
  logic [7:0]     cdb_val;

  logic [3:0] rid [N];
  logic [7:0] flg [N];
  logic [7:0] wb  [N];
  logic [7:0] val [N];

  always #5 clk = ~clk;

  always_comb begin
    fu_robid = '0;
    fu_flags = '0;
    fu_wbs   = '0;
    fu_value = '0;
    for (int i = 0; i < N; i++) begin
      fu_robid[i*4 +: 4] = rid[i];
      fu_flags[i*8 +: 8] = flg[i];
      fu_wbs[i*8 +: 8]   = wb[i];
      fu_value[i*8 +: 8] = val[i];
    end
  end

  fu_completion_arbiter #(.FU_COUNT(N), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fv), .fu_ready(fu_ready),
    .fu_robid(fu_robid), .fu_flags(fu_flags), .fu_wbs(fu_wbs), .fu_value(fu_value),
    .rob_ready(rob_ready), .rob_transmit(rob_transmit),
    .rob_id(rob_id), .rob_flags(rob_flags), .rob_wbs(rob_wbs), .rob_value(rob_value),
    .cdb_transmit(cdb_transmit), .cdb_id(cdb_id), .cdb_val(cdb_val)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: per-FU queues, round-robin pointer, one output slot.
  typedef struct packed {
    logic [3:0] id;
    logic [7:0] fl;
    logic [7:0] wb;
    logic [7:0] v;
  } ent_t;

  ent_t       q [N][$];
  ent_t       exp_q[$];
  int         rr;
  bit         m_valid;
  bit         m_cdb;
  logic [3:0] m_cdb_id;
  logic [7:0] m_cdb_val;
  bit         acc [N];
  bit         m_flushed;
  bit         m_load;
  int         m_win;
  int         m_idx;
  ent_t       m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        acc[i] = 0;
      end
      exp_q.delete();
      rr = 0;
      m_valid = 0;
      m_cdb = 0;
      m_flushed = 0;
    end else begin
      m_cdb = 0;
      m_flushed = flush;
      for (int i = 0; i < N; i++) acc[i] = 0;
      if (flush) begin
        if (m_valid && !rob_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        for (int i = 0; i < N; i++) q[i].delete();
        m_valid = 0;
      end else begin
        for (int i = 0; i < N; i++) acc[i] = fv[i] && (q[i].size() < D);
        m_load = !m_valid || rob_ready;
        if (m_load) begin
          m_win = -1;
          for (int k = 0; k < N; k++) begin
            m_idx = (rr + k) % N;
            if (m_win < 0 && q[m_idx].size() > 0) m_win = m_idx;
          end
          if (m_win >= 0) begin
            m_e = q[m_win].pop_front();
            exp_q.push_back(m_e);
            m_valid   = 1;
            m_cdb     = m_e.fl[0];
            m_cdb_id  = m_e.wb[3:0];
            m_cdb_val = m_e.v;
            rr = (m_win + 1) % N;
          end else begin
            m_valid = 0;
          end
        end
        for (int i = 0; i < N; i++)
          if (acc[i]) q[i].push_back({rid[i], flg[i], wb[i], val[i]});
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the clock edge.
  logic [3:0] log_q[$];
  int         cdb_cnt = 0;
  logic [N-1:0] er;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rob_transmit", rob_transmit, 0);
      chk("rst_cdb_transmit", cdb_transmit, 0);
      chk("rst_fu_ready", fu_ready, 0);
    end else begin
      for (int i = 0; i < N; i++) er[i] = (q[i].size() < D);
      chk("fu_ready", fu_ready, er);
      chk("rob_transmit", rob_transmit, m_valid);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          chk("rob_id",    rob_id,    exp_q[0].id);
          chk("rob_flags", rob_flags, exp_q[0].fl);
          chk("rob_wbs",   rob_wbs,   exp_q[0].wb);
          chk("rob_value", rob_value, exp_q[0].v);
          if (rob_ready) void'(exp_q.pop_front());
        end
      end
      chk("cdb_transmit", cdb_transmit, m_cdb);
      if (m_cdb) begin
        chk("cdb_id",  cdb_id,  m_cdb_id);
        chk("cdb_val", cdb_val, m_cdb_val);
      end
      if (rob_transmit && rob_ready) log_q.push_back(rob_id);
      if (cdb_transmit) cdb_cnt++;
    end
  end

  // Inputs change only 1ns after a rising edge; accepted or flushed requests are withdrawn.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] || m_flushed) fv[i] = 1'b0;
  endtask

  task automatic present(input int i, input logic [3:0] id, input logic [7:0] f,
                         input logic [7:0] w, input logic [7:0] v);
    fv[i] = 1'b1; rid[i] = id; flg[i] = f; wb[i] = w; val[i] = v;
  endtask

  task automatic wait_acc(input int i);
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (acc[i]) return;
    end
    chk("accept_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    fv = '0;
    flush = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  int cdb_before;
  int pv;
  logic [3:0] r4;

  initial begin
    rst = 1'b1; flush = 1'b0; rob_ready = 1'b0; fv = '0;
    for (int i = 0; i < N; i++) begin
      rid[i] = '0; flg[i] = '0; wb[i] = '0; val[i] = '0;
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", fu_ready, 8'hFF);
    chk("post_reset_transmit", rob_transmit, 0);
    cyc();

    // single completion latency and CDB content
    rob_ready = 1'b1;
    present(0, 4'd3, 8'h01, 8'h21, 8'h5A);
    wait_acc(0);
    @(negedge clk);
    chk("lat_not_yet", rob_transmit, 0);
    @(negedge clk);
    chk("lat_valid", rob_transmit, 1);
    chk("lat_id", rob_id, 4'd3);
    chk("lat_cdb", cdb_transmit, 1);
    chk("lat_cdb_id", cdb_id, 4'd1);
    chk("lat_cdb_val", cdb_val, 8'h5A);
    idle(3);

    // three simultaneous FUs from rr_ptr=0
    present(7, 4'hE, 8'h00, 8'h00, 8'h00);
    wait_acc(7);
    idle(4);
    log_q.delete(); cdb_cnt = 0;
    present(0, 4'd1, 8'h01, 8'h34, 8'h11);
    present(1, 4'd2, 8'h00, 8'h56, 8'h22);
    present(2, 4'd3, 8'h01, 8'h78, 8'h33);
    wait_acc(0);
    idle(6);
    chk("rr3_count", log_q.size(), 3);
    if (log_q.size() == 3) chk("rr3_order", {log_q[0], log_q[1], log_q[2]}, 12'h123);
    chk("rr3_cdb_pulses", cdb_cnt, 2);
    log_q.delete();
    present(2, 4'd9, 8'h00, 8'h00, 8'h01);
    present(3, 4'd8, 8'h00, 8'h00, 8'h02);
    wait_acc(2);
    idle(5);
    chk("rr_after3_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("rr_after3_order", {log_q[0], log_q[1]}, 8'h89);

    // backpressure fills FU5
    log_q.delete(); cdb_cnt = 0;
    rob_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      present(5, 4'(4 + n), 8'h01, 8'(8'hA0 + n), 8'(8'h40 + n));
      wait_acc(5);
    end
    @(negedge clk);
    chk("full_ready5", fu_ready[5], 0);
    chk("full_held_valid", rob_transmit, 1);
    chk("full_held_id", rob_id, 4'd4);
    chk("full_one_pulse", cdb_cnt, 1);
    idle(2);
    chk("full_still_one_pulse", cdb_cnt, 1);
    rob_ready = 1'b1;
    idle(6);
    chk("full_count", log_q.size(), 3);
    if (log_q.size() == 3) chk("full_order", {log_q[0], log_q[1], log_q[2]}, 12'h456);
    chk("full_pulses", cdb_cnt, 3);

    // flush with partly filled FIFOs and a held output
    log_q.delete();
    rob_ready = 1'b0;
    present(1, 4'd1, 8'h01, 8'h11, 8'h01);
    present(2, 4'd2, 8'h01, 8'h12, 8'h02);
    present(3, 4'd3, 8'h01, 8'h13, 8'h03);
    cyc();
    present(1, 4'd5, 8'h01, 8'h15, 8'h05);
    present(2, 4'd6, 8'h01, 8'h16, 8'h06);
    cyc();
    present(4, 4'd7, 8'h01, 8'h17, 8'h07);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cdb_before = cdb_cnt;
    @(negedge clk);
    chk("flush_transmit", rob_transmit, 0);
    chk("flush_ready", fu_ready, 8'hFF);
    chk("flush_cdb", cdb_transmit, 0);
    cyc();
    rob_ready = 1'b1;
    idle(6);
    chk("flush_no_output", log_q.size(), 0);
    chk("flush_no_pulse", cdb_cnt, cdb_before);

    // round-robin wrap from rr_ptr=7
    present(6, 4'd6, 8'h00, 8'h00, 8'h00);
    wait_acc(6);
    idle(4);
    log_q.delete();
    present(7, 4'd7, 8'h00, 8'h00, 8'h00);
    present(0, 4'hA, 8'h00, 8'h00, 8'h00);
    wait_acc(7);
    idle(5);
    chk("wrap_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("wrap_order", {log_q[0], log_q[1]}, 8'h7A);
    log_q.delete();
    present(0, 4'hB, 8'h00, 8'h00, 8'h00);
    present(1, 4'hC, 8'h00, 8'h00, 8'h00);
    wait_acc(0);
    idle(5);
    chk("wrap_rr1_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("wrap_rr1_order", {log_q[0], log_q[1]}, 8'hCB);

    // randomized traffic with a mid-run asynchronous reset
    for (int c = 0; c < 2500; c++) begin
      cyc();
      if (c == 1200) begin
        do_reset();
        @(negedge clk);
        chk("mid_reset_ready", fu_ready, 8'hFF);
        chk("mid_reset_transmit", rob_transmit, 0);
        continue;
      end
      pv = ((c / 500) % 2 == 1) ? 70 : 25;
      rob_ready = ($urandom_range(0, 99) < 65);
      flush = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!fv[i] && $urandom_range(0, 99) < pv) begin
          r4 = 4'($urandom);
          present(i, r4, 8'($urandom), 8'($urandom), 8'($urandom));
        end
      end
    end

    // drain
    flush = 1'b0;
    fv = '0;
    rob_ready = 1'b1;
    idle(40);
    @(negedge clk);
    chk("drain_transmit", rob_transmit, 0);
    chk("drain_ready", fu_ready, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
